bus_mux_arb: RTL and testbench
==============================

Name: bus_mux_arb

Overview:
- Parametrised N-channel bus multiplexer with a built-in arbiter.
- Successor to the fixed 3-input 32-bit bus mux: the external select is replaced by request/grant arbitration, and the output is registered.
- Sits between several bus sources (registers, memory read ports, ALU) and a shared data bus.
- Owner holds the bus while requesting. An optional hold limit forces hand-over when other sources are waiting.

Parameters:
- WIDTH, 32, data width of each channel and of the output bus.
- NCH, 4, number of channels; legal range 2..8.
- MODE, 0, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round-robin.
- MAX_HOLD, 0, maximum consecutive owned cycles before forced release when another request is pending; 0 = unlimited.
- IW (localparam), clog2(NCH), width of grant_idx.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NCH  per-channel bus request, level-sensitive.
- d_in  in  NCH*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- grant  out  NCH  one-hot grant, registered; all zero when idle.
- grant_idx  out  IW  index of current owner; 0 when idle.
- y  out  WIDTH  registered bus output.
- y_valid  out  1  high when y carries owner data.

Behaviour:
- One clock; reset is synchronous and active-high. When reset is sampled high at a clk edge, the following values apply:
  - state=IDLE, grant=0, grant_idx=0, y=0, y_valid=0.
  - RR pointer=0, hold counter=0.
  - Reset mid-ownership drops the grant at that same edge.
- FSM states: IDLE, BUSY.
- IDLE:
  - If req != 0, the winner is chosen combinationally.
  - At the next edge: grant=onehot(winner), grant_idx=winner, state=BUSY.
  - Otherwise stay in IDLE, with y=0 and y_valid=0.
- BUSY, owner o:
  - Each edge: y <= d_in[o], y_valid <= 1. Data latency is 1 cycle from d_in to y.
  - The first y_valid appears one edge after grant rises, i.e. 2 edges after req.
- Release: if req[o]=0 at an edge, the owner is released.
  - If another req is set, the new winner is granted at that same edge (no idle cycle), and y_valid stays 0 for that edge.
  - Otherwise state goes to IDLE, grant=0, y=0, y_valid=0.
- Fixed priority (MODE=0): the lowest-indexed active req wins.
- Round-robin (MODE=1):
  - The search starts at ptr and wraps from NCH-1 to 0.
  - When a grant to k is issued, ptr <= (k+1) mod NCH.
- Hold limit (MAX_HOLD>0):
  - hold counter counts owned cycles, clears on each new grant, and saturates at MAX_HOLD.
  - When count reaches MAX_HOLD and any other req is active, the owner is forcibly released.
  - Re-arbitration excludes the current owner for that decision. The owner may re-request and win later.
  - If no other req is pending, the owner keeps the bus and the counter stays saturated.
- Simultaneous requests are resolved only by the mode rule; the grant is always one-hot or zero.
- A req dropped and re-raised by the owner within one cycle counts as release followed by a new request.
- d_in of non-owners is ignored. The output is never X: default y=0.

Test Plan:
- Reset during BUSY (owner 2, y=0xA5A5A5A5): assert reset 1 cycle -> next edge grant=0, y=0, y_valid=0, state IDLE.
- MODE=0, NCH=4: req=4'b1010 from IDLE, d_in[1]=0x11111111 -> grant=4'b0010 after 1 edge; y=0x11111111, y_valid=1 after 2 edges.
- MODE=0 handover: owner 1 drops req while req[3]=1, d_in[3]=0x33333333 -> same edge grant=4'b1000, y_valid=0 for that edge, then y=0x33333333.
- MODE=1: all four req held, each owner drops req after 3 cycles then re-raises -> grant order 0,1,2,3,0; never repeats an owner while others wait.
- MAX_HOLD=4, MODE=0: ch0 holds req, ch2 requests at cycle 1 -> ch0 forced off after 4 owned cycles, grant=4'b0100; with ch2 absent, ch0 keeps the bus indefinitely.
- WIDTH=8, NCH=2: req=0 throughout -> y=0x00, y_valid=0, grant=2'b00 every cycle.

Source files
------------

// File: rtl/bus_mux_arb.sv
// Registered N-channel bus multiplexer with a built-in request/grant arbiter.
// Fixed-priority or round-robin selection, with an optional hold limit that forces hand-over.
module bus_mux_arb #(
    parameter int WIDTH    = 32,
    parameter int NCH      = 4,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 0,
    localparam int IW      = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] d_in,
    output logic [NCH-1:0]       grant,
    output logic [IW-1:0]        grant_idx,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [NCH-1:0]   grant_nxt;
    logic [IW-1:0]    idx_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [HW-1:0]    hold, hold_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic             y_valid_nxt;

    logic [NCH-1:0]   owner_mask;
    logic [NCH-1:0]   cand;
    logic [IW-1:0]    win;
    logic             win_ok;
    logic             others;
    logic             hold_hit;
    logic             release_o;
    logic             do_grant;

    // Search position for offset 'off'; round-robin starts at the pointer and wraps.
    function automatic logic [IW-1:0] search_pos(input logic [IW-1:0] base, input int off);
        int s;
        s = (MODE == 1) ? int'(base) + off : off;
        if (s >= NCH) s = s - NCH;
        return IW'(s);
    endfunction

    always_comb begin
        owner_mask = {{(NCH-1){1'b0}}, 1'b1} << grant_idx;
        others     = |(req & ~owner_mask);
        hold_hit   = (MAX_HOLD > 0) && (hold == HW'(MAX_HOLD));
        release_o  = !req[grant_idx] || (hold_hit && others);
        // While busy the current owner never takes part in re-arbitration.
        cand       = (state == BUSY) ? (req & ~owner_mask) : req;
    end

    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!win_ok && cand[search_pos(ptr, i)]) begin
                win    = search_pos(ptr, i);
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        idx_nxt     = grant_idx;
        ptr_nxt     = ptr;
        hold_nxt    = hold;
        y_nxt       = '0;
        y_valid_nxt = 1'b0;
        do_grant    = 1'b0;

        case (state)
            IDLE: begin
                do_grant = win_ok;
            end
            BUSY: begin
                if (!release_o) begin
                    y_nxt       = d_in[int'(grant_idx)*WIDTH +: WIDTH];
                    y_valid_nxt = 1'b1;
                    if (MAX_HOLD > 0 && hold != HW'(MAX_HOLD))
                        hold_nxt = hold + 1'b1;
                end else if (win_ok) begin
                    do_grant = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    idx_nxt   = '0;
                    hold_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                idx_nxt   = '0;
            end
        endcase

        if (do_grant) begin
            state_nxt = BUSY;
            grant_nxt = {{(NCH-1){1'b0}}, 1'b1} << win;
            idx_nxt   = win;
            hold_nxt  = '0;
            if (MODE == 1)
                ptr_nxt = (win == IW'(NCH-1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= '0;
            hold      <= '0;
            y         <= '0;
            y_valid   <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
            ptr       <= ptr_nxt;
            hold      <= hold_nxt;
            y         <= y_nxt;
            y_valid   <= y_valid_nxt;
        end
    end

endmodule

// File: tb/tb_bus_mux_arb.sv
// Bench for bus_mux_arb: four instances (fixed priority, round-robin, hold limit, narrow idle)
// compared every cycle against an owner/pointer reference model plus directed scenario checks.
module tb_bus_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [3:0]   req;
    logic [127:0] d_in;
    logic [1:0]   req_b;
    logic [15:0]  d_in_b;

    logic [3:0]   grant_w [3];
    logic [1:0]   idx_w   [3];
    logic [31:0]  y_w     [3];
    logic         v_w     [3];
    logic [1:0]   grant_b;
    logic         idx_b;
    logic [7:0]   y_b;
    logic         v_b;

    bus_mux_arb #(.WIDTH(32), .NCH(4), .MODE(0), .MAX_HOLD(0)) dut_fp (
        .clk(clk), .reset(reset), .req(req), .d_in(d_in),
        .grant(grant_w[0]), .grant_idx(idx_w[0]), .y(y_w[0]), .y_valid(v_w[0]));

    bus_mux_arb #(.WIDTH(32), .NCH(4), .MODE(1), .MAX_HOLD(0)) dut_rr (
        .clk(clk), .reset(reset), .req(req), .d_in(d_in),
        .grant(grant_w[1]), .grant_idx(idx_w[1]), .y(y_w[1]), .y_valid(v_w[1]));

    bus_mux_arb #(.WIDTH(32), .NCH(4), .MODE(0), .MAX_HOLD(4)) dut_mh (
        .clk(clk), .reset(reset), .req(req), .d_in(d_in),
        .grant(grant_w[2]), .grant_idx(idx_w[2]), .y(y_w[2]), .y_valid(v_w[2]));

    bus_mux_arb #(.WIDTH(8), .NCH(2), .MODE(0), .MAX_HOLD(0)) dut_nb (
        .clk(clk), .reset(reset), .req(req_b), .d_in(d_in_b),
        .grant(grant_b), .grant_idx(idx_b), .y(y_b), .y_valid(v_b));

    int checks = 0;
    int errors = 0;

    int mode_of [3] = '{0, 1, 0};
    int maxh_of [3] = '{0, 0, 4};
    int owner   [3];
    int ptr     [3];
    int held    [3];
    logic [31:0] ey [3];
    logic        ev [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int m, input logic [3:0] r, input int excl);
        int k;
        for (int i = 0; i < 4; i++) begin
            k = (mode_of[m] == 1) ? (ptr[m] + i) % 4 : i;
            if (k != excl && r[k]) return k;
        end
        return -1;
    endfunction

    task automatic grant_to(input int m, input int w);
        owner[m] = w;
        held[m]  = 0;
        ptr[m]   = (w + 1) % 4;
    endtask

    task automatic model_step(input int m);
        int  w;
        int  o;
        bit  oth;
        ey[m] = 32'h0;
        ev[m] = 1'b0;
        if (reset) begin
            owner[m] = -1;
            ptr[m]   = 0;
            held[m]  = 0;
        end else if (owner[m] < 0) begin
            w = pick(m, req, -1);
            if (w >= 0) grant_to(m, w);
        end else begin
            o   = owner[m];
            oth = (req & ~(4'b0001 << o)) != 4'b0000;
            if (req[o] && !(maxh_of[m] > 0 && held[m] >= maxh_of[m] && oth)) begin
                ey[m] = d_in[o*32 +: 32];
                ev[m] = 1'b1;
                held[m]++;
            end else begin
                w = pick(m, req, o);
                if (w >= 0) grant_to(m, w);
                else owner[m] = -1;
            end
        end
    endtask

    task automatic tick();
        for (int m = 0; m < 3; m++) model_step(m);
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            check($sformatf("grant%0d", m), 32'(grant_w[m]), (owner[m] < 0) ? 32'h0 : 32'(1) << owner[m]);
            check($sformatf("grant_idx%0d", m), 32'(idx_w[m]), (owner[m] < 0) ? 32'h0 : 32'(owner[m]));
            check($sformatf("y%0d", m), y_w[m], ey[m]);
            check($sformatf("y_valid%0d", m), 32'(v_w[m]), 32'(ev[m]));
        end
        check("nb_grant", 32'(grant_b), 32'h0);
        check("nb_idx", 32'(idx_b), 32'h0);
        check("nb_y", 32'(y_b), 32'h0);
        check("nb_y_valid", 32'(v_b), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int vcnt;
        reset  = 1'b1;
        req    = 4'b0000;
        d_in   = '0;
        req_b  = 2'b00;
        d_in_b = 16'hBEEF;
        for (int m = 0; m < 3; m++) begin
            owner[m] = -1; ptr[m] = 0; held[m] = 0; ey[m] = 0; ev[m] = 0;
        end
        tick();
        tick();
        check("rst_grant", 32'(grant_w[0]), 32'h0);
        check("rst_y_valid", 32'(v_w[0]), 32'h0);
        reset = 1'b0;

        // fixed-priority first grant and one-cycle data latency
        d_in[1*32 +: 32] = 32'h11111111;
        d_in[3*32 +: 32] = 32'h33333333;
        req = 4'b1010;
        tick();
        check("fp_grant", 32'(grant_w[0]), 32'h2);
        check("fp_first_valid", 32'(v_w[0]), 32'h0);
        tick();
        check("fp_y", y_w[0], 32'h11111111);
        check("fp_y_valid", 32'(v_w[0]), 32'h1);

        // owner drops while another request waits: hand-over at the same edge
        req = 4'b1000;
        tick();
        check("ho_grant", 32'(grant_w[0]), 32'h8);
        check("ho_y_valid", 32'(v_w[0]), 32'h0);
        tick();
        check("ho_y", y_w[0], 32'h33333333);

        // reset while channel 2 owns the bus
        d_in[2*32 +: 32] = 32'hA5A5A5A5;
        req = 4'b0100;
        tick();
        tick();
        check("busy_y", y_w[0], 32'hA5A5A5A5);
        check("busy_idx", 32'(idx_w[0]), 32'h2);
        reset = 1'b1;
        tick();
        check("mid_rst_grant", 32'(grant_w[0]), 32'h0);
        check("mid_rst_y", y_w[0], 32'h0);
        check("mid_rst_y_valid", 32'(v_w[0]), 32'h0);
        reset = 1'b0;
        req = 4'b0000;
        tick();

        // round-robin rotation with every channel requesting
        do_reset();
        req = 4'b1111;
        tick();
        check("rr_order0", 32'(idx_w[1]), 32'h0);
        for (int g = 1; g <= 4; g++) begin
            tick(); tick(); tick();
            req = 4'b1111 & ~(4'b0001 << ((g - 1) % 4));
            tick();
            check($sformatf("rr_order%0d", g), 32'(idx_w[1]), 32'(g % 4));
            req = 4'b1111;
        end
        tick();

        // hold limit forces channel 0 off once channel 2 waits
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0101;
        vcnt = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (v_w[2] && idx_w[2] == 2'd0) vcnt++;
            if (grant_w[2] == 4'b0100) break;
        end
        check("mh_handover", 32'(grant_w[2]), 32'h4);
        check("mh_owned_cycles", 32'(vcnt), 32'd4);
        check("mh_unlimited_keeps", 32'(grant_w[0]), 32'h1);

        // with nobody else waiting the limited owner keeps the bus
        do_reset();
        req = 4'b0001;
        repeat (20) tick();
        check("mh_keep_grant", 32'(grant_w[2]), 32'h1);
        check("mh_keep_valid", 32'(v_w[2]), 32'h1);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            for (int b = 0; b < 4; b++)
                d_in[b*32 +: 32] = $urandom;
            d_in_b = 16'($urandom);
            tick();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
